// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: sequences word/byte/indirect/TRAP accesses onto a single-port dmem.
// Latency: 3 cycles simple, 4+GAP_CYCLES indirect (no-wait memory); mem_stall holds the pipe until DONE.
module mem_stage_ctrl #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stage_valid,
    input  logic [3:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        lshf_enable,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_stall,
    output logic [15:0] load_data,
    output logic        load_data_valid
);
    typedef enum logic [2:0] {IDLE, PHASE1, GAP, PHASE2, DONE} state_t;

    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        lshf_q, lshf_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] load_q, load_d;
    logic [1:0]  gap_q, gap_d;

    logic        is_wr, is_ind, is_ld;
    logic [7:0]  rbyte;

    assign is_wr  = (op_q == OP_STR) || (op_q == OP_STB);
    assign is_ind = (op_q == OP_LDI) || (op_q == OP_STI);
    assign is_ld  = !is_wr && (op_q != OP_STI);
    assign rbyte  = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign load_data = load_q;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        lshf_d           = lshf_q;
        ptr_d            = ptr_q;
        load_d           = load_q;
        gap_d            = gap_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        mem_stall        = 1'b0;
        load_data_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stage_valid && (mem_read || mem_write)) begin
                    mem_stall = 1'b1;
                    op_d      = opcode;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    lshf_d    = lshf_enable;
                    state_d   = PHASE1;
                end
            end
            PHASE1: begin
                mem_stall    = 1'b1;
                dmem_address = {addr_q[15:1], 1'b0};
                if (is_wr) begin
                    dmem_write = 1'b1;
                    if (lshf_q) begin
                        dmem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
                        dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    end else begin
                        dmem_wdata       = wdata_q;
                        dmem_byte_enable = 2'b11;
                    end
                end else begin
                    dmem_read = 1'b1;
                end
                if (dmem_resp) begin
                    if (is_ind) begin
                        ptr_d   = dmem_rdata;
                        gap_d   = 2'd0;
                        state_d = (GAP_CYCLES == 0) ? PHASE2 : GAP;
                    end else begin
                        if (!is_wr)
                            load_d = lshf_q ? {{8{rbyte[7]}}, rbyte} : dmem_rdata;
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                mem_stall = 1'b1;
                if (gap_q == GAP_LAST) state_d = PHASE2;
                else                   gap_d   = gap_q + 2'd1;
            end
            PHASE2: begin
                mem_stall    = 1'b1;
                dmem_address = {ptr_q[15:1], 1'b0};
                if (op_q == OP_STI) begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = wdata_q;
                    dmem_byte_enable = 2'b11;
                end else begin
                    dmem_read = 1'b1;
                end
                if (dmem_resp) begin
                    if (op_q != OP_STI) load_d = dmem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipe advances on this edge, so no re-trigger check is needed here
                load_data_valid = is_ld;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'h0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            lshf_q  <= 1'b0;
            ptr_q   <= 16'h0000;
            load_q  <= 16'h0000;
            gap_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lshf_q  <= lshf_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
            gap_q   <= gap_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench: u0 runs with a one-cycle indirect gap, u1 with no gap; both share stimulus.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, sv, mr, mw, ls, resp;
    logic [3:0]  op;
    logic [15:0] addr, wd, rdata;

    logic        rd0, wr0, st0, lv0, rd1, wr1, st1, lv1;
    logic [15:0] a0, wd0, ld0, a1, wd1, ld1;
    logic [1:0]  be0, be1;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.GAP_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .stage_valid(sv), .opcode(op), .mem_read(mr),
        .mem_write(mw), .lshf_enable(ls), .addr(addr), .wdata(wd), .dmem_resp(resp),
        .dmem_rdata(rdata), .dmem_read(rd0), .dmem_write(wr0), .dmem_address(a0),
        .dmem_wdata(wd0), .dmem_byte_enable(be0), .mem_stall(st0), .load_data(ld0),
        .load_data_valid(lv0)
    );

    mem_stage_ctrl #(.GAP_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .stage_valid(sv), .opcode(op), .mem_read(mr),
        .mem_write(mw), .lshf_enable(ls), .addr(addr), .wdata(wd), .dmem_resp(resp),
        .dmem_rdata(rdata), .dmem_read(rd1), .dmem_write(wr1), .dmem_address(a1),
        .dmem_wdata(wd1), .dmem_byte_enable(be1), .mem_stall(st1), .load_data(ld1),
        .load_data_valid(lv1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ldb(input logic [15:0] a, input logic [15:0] rdv, input logic [15:0] exp);
        sv = 1'b1; op = 4'b0010; mr = 1'b1; ls = 1'b1; addr = a;
        tick();
        chk("ldb_rd", {15'd0, rd0}, 16'd1);
        chk("ldb_addr", a0, {a[15:1], 1'b0});
        resp = 1'b1; rdata = rdv;
        tick();
        resp = 1'b0; sv = 1'b0; mr = 1'b0; ls = 1'b0;
        chk("ldb_data", ld0, exp);
        chk("ldb_valid", {15'd0, lv0}, 16'd1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; sv = 1'b0; op = 4'h0; mr = 1'b0; mw = 1'b0; ls = 1'b0;
        addr = 16'h0; wd = 16'h0; resp = 1'b0; rdata = 16'h0;
        tick();
        tick();
        chk("rst_rd", {15'd0, rd0}, 16'd0);
        chk("rst_wr", {15'd0, wr0}, 16'd0);
        chk("rst_addr", a0, 16'h0000);
        chk("rst_wdata", wd0, 16'h0000);
        chk("rst_be", {14'd0, be0}, 16'd0);
        chk("rst_stall", {15'd0, st0}, 16'd0);
        chk("rst_ld", ld0, 16'h0000);
        chk("rst_lv", {15'd0, lv0}, 16'd0);
        rst_n = 1'b1;
        tick();

        // LDR with two wait cycles
        sv = 1'b1; op = 4'b0110; mr = 1'b1; addr = 16'h3001;
        #1;
        chk("ldr_idle_stall", {15'd0, st0}, 16'd1);
        chk("ldr_idle_rd", {15'd0, rd0}, 16'd0);
        tick();
        chk("ldr_p1_rd", {15'd0, rd0}, 16'd1);
        chk("ldr_p1_addr", a0, 16'h3000);
        chk("ldr_p1_stall", {15'd0, st0}, 16'd1);
        tick();
        chk("ldr_w1_rd", {15'd0, rd0}, 16'd1);
        tick();
        chk("ldr_w2_rd", {15'd0, rd0}, 16'd1);
        chk("ldr_w2_stall", {15'd0, st0}, 16'd1);
        resp = 1'b1; rdata = 16'hBEEF;
        tick();
        resp = 1'b0;
        chk("ldr_done_rd", {15'd0, rd0}, 16'd0);
        chk("ldr_done_stall", {15'd0, st0}, 16'd0);
        chk("ldr_done_lv", {15'd0, lv0}, 16'd1);
        chk("ldr_done_ld", ld0, 16'hBEEF);
        sv = 1'b0; mr = 1'b0;
        tick();
        chk("ldr_after_lv", {15'd0, lv0}, 16'd0);
        chk("ldr_after_ld", ld0, 16'hBEEF);
        chk("ldr_after_stall", {15'd0, st0}, 16'd0);

        ldb(16'h2005, 16'h8041, 16'hFF80);
        ldb(16'h2004, 16'h8041, 16'h0041);

        // STB to odd byte
        sv = 1'b1; op = 4'b0011; mw = 1'b1; ls = 1'b1; addr = 16'h1003; wd = 16'h12AB;
        tick();
        chk("stb_wr", {15'd0, wr0}, 16'd1);
        chk("stb_rd", {15'd0, rd0}, 16'd0);
        chk("stb_wdata", wd0, 16'hABAB);
        chk("stb_be", {14'd0, be0}, 16'd2);
        chk("stb_addr", a0, 16'h1002);
        resp = 1'b1;
        tick();
        resp = 1'b0; sv = 1'b0; mw = 1'b0; ls = 1'b0;
        chk("stb_done_lv", {15'd0, lv0}, 16'd0);
        chk("stb_done_wr", {15'd0, wr0}, 16'd0);
        chk("stb_done_stall", {15'd0, st0}, 16'd0);
        chk("stb_ld_hold", ld0, 16'h0041);
        tick();

        // STI: u0 inserts one gap cycle, u1 goes straight to phase 2
        sv = 1'b1; op = 4'b1011; mr = 1'b1; addr = 16'h4000; wd = 16'h7777;
        tick();
        chk("sti_p1_rd", {15'd0, rd0}, 16'd1);
        chk("sti_p1_wr", {15'd0, wr0}, 16'd0);
        chk("sti_p1_addr", a0, 16'h4000);
        resp = 1'b1; rdata = 16'h5003;
        tick();
        resp = 1'b0;
        chk("sti_gap_rd", {15'd0, rd0}, 16'd0);
        chk("sti_gap_wr", {15'd0, wr0}, 16'd0);
        chk("sti_gap_stall", {15'd0, st0}, 16'd1);
        chk("sti_nogap_wr", {15'd0, wr1}, 16'd1);
        chk("sti_nogap_addr", a1, 16'h5002);
        tick();
        chk("sti_p2_wr", {15'd0, wr0}, 16'd1);
        chk("sti_p2_rd", {15'd0, rd0}, 16'd0);
        chk("sti_p2_addr", a0, 16'h5002);
        chk("sti_p2_wdata", wd0, 16'h7777);
        chk("sti_p2_be", {14'd0, be0}, 16'd3);
        resp = 1'b1;
        tick();
        resp = 1'b0; sv = 1'b0; mr = 1'b0;
        chk("sti_done_stall", {15'd0, st0}, 16'd0);
        chk("sti_done_lv", {15'd0, lv0}, 16'd0);
        chk("sti_done_wr", {15'd0, wr0}, 16'd0);
        tick();

        // LDI on the no-gap instance
        sv = 1'b1; op = 4'b1010; mr = 1'b1; addr = 16'h3FFE;
        tick();
        chk("ldi_p1_rd", {15'd0, rd1}, 16'd1);
        chk("ldi_p1_addr", a1, 16'h3FFE);
        resp = 1'b1; rdata = 16'h6000;
        tick();
        chk("ldi_p2_rd", {15'd0, rd1}, 16'd1);
        chk("ldi_p2_addr", a1, 16'h6000);
        chk("ldi_gap_rd_u0", {15'd0, rd0}, 16'd0);
        rdata = 16'h0042;
        tick();
        resp = 1'b0;
        chk("ldi_done_ld", ld1, 16'h0042);
        chk("ldi_done_lv", {15'd0, lv1}, 16'd1);
        chk("ldi_done_stall", {15'd0, st1}, 16'd0);
        chk("ldi_u0_p2_rd", {15'd0, rd0}, 16'd1);
        chk("ldi_u0_p2_addr", a0, 16'h6000);
        sv = 1'b0; mr = 1'b0;
        tick();
        chk("ldi_after_lv", {15'd0, lv1}, 16'd0);
        chk("ldi_u0_wait_stall", {15'd0, st0}, 16'd1);

        // Reset while u0 sits in LDI phase 2, then a late response
        rst_n = 1'b0;
        tick();
        chk("rmid_rd", {15'd0, rd0}, 16'd0);
        chk("rmid_stall", {15'd0, st0}, 16'd0);
        chk("rmid_addr", a0, 16'h0000);
        chk("rmid_ld", ld0, 16'h0000);
        chk("rmid_lv", {15'd0, lv0}, 16'd0);
        rst_n = 1'b1; resp = 1'b1; rdata = 16'h1234;
        tick();
        resp = 1'b0;
        chk("late_rd", {15'd0, rd0}, 16'd0);
        chk("late_stall", {15'd0, st0}, 16'd0);
        chk("late_lv", {15'd0, lv0}, 16'd0);
        chk("late_ld", ld0, 16'h0000);
        chk("late_ld_u1", ld1, 16'h0000);
        tick();
        chk("late2_ld", ld0, 16'h0000);
        chk("late2_lv", {15'd0, lv0}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
